data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_pkg.sv | 62 ++++++
 rtl/data_mem_responder_if.sv | 44 ++++
 rtl/data_mem_responder_console_fifo.sv | 89 ++++++++
 rtl/data_mem_responder.sv | 147 ++++++++++++++
 tb/tb_data_mem_responder.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_responder_pkg
// Shared definitions for the data-memory responder: the memory map, the
// STATUS register bit layout, the address-region enumeration, and two small
// helpers. The helpers decode a word address into a region and pack the
// STATUS word.
// -----------------------------------------------------------------------------
package data_mem_responder_pkg;

  // Memory map (byte addresses). The two address LSBs are never decoded.
  localparam logic [31:0] RAM_BASE    = 32'h0000_0000;  // 256-byte window
  localparam logic [31:0] CYCLE_ADDR  = 32'h0000_1000;
  localparam logic [31:0] CONTX_ADDR  = 32'h0000_1004;
  localparam logic [31:0] STATUS_ADDR = 32'h0000_1008;

  // STATUS register layout; every bit not listed here reads as zero.
  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_OVF_BIT   = 2;
  localparam int STATUS_COUNT_LSB = 3;
  localparam int STATUS_COUNT_MSB = 5;

  typedef enum logic [2:0] {
    REGION_NONE   = 3'd0,
    REGION_RAM    = 3'd1,
    REGION_CYCLE  = 3'd2,
    REGION_CONTX  = 3'd3,
    REGION_STATUS = 3'd4
  } region_e;

  // Decode a word address (byte address bits [31:2]) into its region.
  function automatic region_e decode_region(input logic [29:0] word_addr);
    region_e r;
    if (word_addr[29:6] == RAM_BASE[31:8]) begin
      r = REGION_RAM;
    end else if (word_addr == CYCLE_ADDR[31:2]) begin
      r = REGION_CYCLE;
    end else if (word_addr == CONTX_ADDR[31:2]) begin
      r = REGION_CONTX;
    end else if (word_addr == STATUS_ADDR[31:2]) begin
      r = REGION_STATUS;
    end else begin
      r = REGION_NONE;
    end
    return r;
  endfunction

  // Assemble the STATUS read word from the individual FIFO flags.
  function automatic logic [31:0] pack_status(input logic       full,
                                              input logic       empty,
                                              input logic       ovf,
                                              input logic [2:0] count);
    logic [31:0] w;
    w                                     = 32'h0000_0000;
    w[STATUS_FULL_BIT]                    = full;
    w[STATUS_EMPTY_BIT]                   = empty;
    w[STATUS_OVF_BIT]                     = ovf;
    w[STATUS_COUNT_MSB:STATUS_COUNT_LSB]  = count;
    return w;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// -----------------------------------------------------------------------------
// data_mem_responder_if
// Bundles the CPU load/store bus and the console byte stream.
//   MemWrite    store strobe, one word per asserted cycle
//   Mem_WrAddr  byte address used by both loads and stores
//   Mem_WrData  store data
//   ReadData    load data (combinational from Mem_WrAddr)
//   con_valid   console byte available
//   con_data    console byte at FIFO head
//   con_ready   console sink accepts the byte when high with con_valid
// The master modport is the CPU/console side. The slave modport is the
// responder.
// -----------------------------------------------------------------------------
interface data_mem_responder_if;

  logic        MemWrite;
  logic [31:0] Mem_WrAddr;
  logic [31:0] Mem_WrData;
  logic [31:0] ReadData;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready;

  modport master (
    output MemWrite,
    output Mem_WrAddr,
    output Mem_WrData,
    output con_ready,
    input  ReadData,
    input  con_valid,
    input  con_data
  );

  modport slave (
    input  MemWrite,
    input  Mem_WrAddr,
    input  Mem_WrData,
    input  con_ready,
    output ReadData,
    output con_valid,
    output con_data
  );

endinterface

// File: rtl/data_mem_responder_console_fifo.sv
// -----------------------------------------------------------------------------
// console_fifo
// Byte FIFO that buffers console output. DEPTH must be a power of two of at
// least 2, so the pointers wrap naturally modulo DEPTH.
//   clk, reset   single clock, synchronous active-high reset (flushes)
//   push_i       write push_data_i. While full, the write is accepted only
//                if there is a pop in the same cycle.
//   pop_i        remove the head byte. This input is ignored when empty.
//   head_o       byte at the head; meaningless when empty_o is set
//   full_o       count_o == DEPTH
//   empty_o      count_o == 0
//   count_o      number of stored bytes (0..DEPTH)
// -----------------------------------------------------------------------------
module console_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [7:0]               push_data_i,
  input  logic                     pop_i,
  output logic [7:0]               head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign empty_o  = (count_q == {CW{1'b0}});
  assign full_o   = (count_q == CW'(DEPTH));
  assign count_o  = count_q;
  assign head_o   = mem_q[rd_ptr_q];

  // A pop frees the head slot this cycle, so a push is allowed even while full.
  assign pop_ok_s  = pop_i && !empty_o;
  assign push_ok_s = push_i && (!full_o || pop_ok_s);

  // Next-state for the pointers and the occupancy count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset flushes the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Byte storage. This storage is not reset; stale slots are unreachable after a flush.
  always_ff @(posedge clk) begin
    if (push_ok_s && !reset) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Data-side memory responder for a small CPU. The memory map is:
//   0x000-0x0FF  RAM of RAM_WORDS 32-bit words. A store commits at the edge,
//                and a same-cycle load returns the old word.
//   0x1000       CYCLE: free-running cycle counter. A store loads the counter.
//   0x1004       CONTX: a store pushes byte [7:0] to the console FIFO.
//                A load returns 0.
//   0x1008       STATUS: {count[5:3], overflow[2], empty[1], full[0]}.
//                A store with bit 2 set clears overflow.
// All other addresses read 0 and ignore stores. Address bits [1:0] are not
// decoded.
// Ports:
//   clk    single clock, rising edge
//   reset  synchronous active-high reset. Clears CYCLE and overflow and
//          flushes the FIFO. The RAM keeps its contents.
//   bus    slave side of data_mem_responder_if (CPU bus + console stream)
// -----------------------------------------------------------------------------
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  region_e       region_s;
  logic [AW-1:0] ram_idx_s;
  logic          ram_wr_s;
  logic          cycle_wr_s;
  logic          contx_wr_s;
  logic          status_wr_s;

  logic [31:0]   ram_q [RAM_WORDS];
  logic [31:0]   cycle_q, cycle_d;
  logic          overflow_q, overflow_d;

  logic          fifo_push_s;
  logic          fifo_pop_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic          drop_s;
  logic [7:0]    fifo_head_s;
  logic [CW-1:0] fifo_count_s;
  logic [2:0]    status_count_s;
  logic [31:0]   rd_data_s;
  logic          unused_addr_lsb_s;

  // Byte-lane bits never take part in decode.
  assign unused_addr_lsb_s = ^bus.Mem_WrAddr[1:0];

  assign region_s  = decode_region(bus.Mem_WrAddr[31:2]);
  assign ram_idx_s = bus.Mem_WrAddr[AW+1:2];

  // Reset blocks every store in its cycle, including RAM stores.
  assign ram_wr_s    = bus.MemWrite && (region_s == REGION_RAM) && !reset;
  assign cycle_wr_s  = bus.MemWrite && (region_s == REGION_CYCLE);
  assign contx_wr_s  = bus.MemWrite && (region_s == REGION_CONTX);
  assign status_wr_s = bus.MemWrite && (region_s == REGION_STATUS);

  // Console handshake. A byte leaves whenever the sink is ready and one is queued.
  assign fifo_pop_s  = !fifo_empty_s && bus.con_ready;
  assign fifo_push_s = contx_wr_s;
  // A push into a full FIFO is lost unless a pop makes room in the same cycle.
  assign drop_s      = fifo_push_s && fifo_full_s && !fifo_pop_s;

  // Next CYCLE value. A store beats the increment, and the increment wraps naturally.
  always_comb begin
    cycle_d = cycle_q;
    if (cycle_wr_s) begin
      cycle_d = bus.Mem_WrData;
    end else begin
      cycle_d = cycle_q + 32'd1;
    end
  end

  // Next sticky-overflow value. A drop in the same cycle wins over a clear request.
  always_comb begin
    overflow_d = overflow_q;
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (status_wr_s && bus.Mem_WrData[STATUS_OVF_BIT]) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // CYCLE and overflow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q    <= 32'h0000_0000;
      overflow_q <= 1'b0;
    end else begin
      cycle_q    <= cycle_d;
      overflow_q <= overflow_d;
    end
  end

  // RAM write port. The contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (ram_wr_s) begin
      ram_q[ram_idx_s] <= bus.Mem_WrData;
    end
  end

  console_fifo #(
    .DEPTH       (FIFO_DEPTH)
  ) u_console_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (fifo_push_s),
    .push_data_i (bus.Mem_WrData[7:0]),
    .pop_i       (fifo_pop_s),
    .head_o      (fifo_head_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .count_o     (fifo_count_s)
  );

  // STATUS has a three-bit count field; FIFO_DEPTH above 4 would not fit it.
  assign status_count_s = 3'(fifo_count_s);

  // Load data mux. This path is asynchronous, so a same-cycle load sees pre-store state.
  always_comb begin
    rd_data_s = 32'h0000_0000;
    case (region_s)
      REGION_RAM:    rd_data_s = ram_q[ram_idx_s];
      REGION_CYCLE:  rd_data_s = cycle_q;
      REGION_CONTX:  rd_data_s = 32'h0000_0000;
      REGION_STATUS: rd_data_s = pack_status(fifo_full_s, fifo_empty_s,
                                             overflow_q, status_count_s);
      default:       rd_data_s = 32'h0000_0000;
    endcase
  end

  assign bus.ReadData  = rd_data_s;
  assign bus.con_valid = !fifo_empty_s;
  assign bus.con_data  = fifo_head_s;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
// Self-checking bench for data_mem_responder. The bench has three parts:
// a table of directed vectors with hand-derived expectations, one hand-written
// push/pop sequence, and randomized traffic. The random traffic is compared
// against a behavioural model built from an array, an integer counter and a
// byte queue.
// Inputs change on the falling edge, and outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  data_mem_responder_if bus_if();

  data_mem_responder #(
    .RAM_WORDS  (64),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        rdy;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_v;
    logic        chk_d;
    logic [7:0]  exp_d;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural reference state.
  logic [31:0] m_ram [64];
  logic [31:0] m_cycle;
  logic [7:0]  m_q[$];
  logic        m_ovf;

  function automatic void add(input logic rst, input logic we,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic rdy, input logic chk_rd,
                              input logic [31:0] exp_rd, input logic exp_v,
                              input logic chk_d, input logic [7:0] exp_d);
    vec_t v;
    v.rst = rst; v.we = we; v.addr = addr; v.wd = wd; v.rdy = rdy;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_v = exp_v;
    v.chk_d = chk_d; v.exp_d = exp_d;
    vecs.push_back(v);
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%02h expected 0x%02h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic rdy);
    reset             = rst;
    bus_if.MemWrite   = we;
    bus_if.Mem_WrAddr = addr;
    bus_if.Mem_WrData = wd;
    bus_if.con_ready  = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Model: value a load of byte address a returns in the current state.
  function automatic logic [31:0] m_status();
    int n;
    logic [31:0] s;
    n = m_q.size();
    s = 32'(n) << 3;
    if (n == DEPTH) s = s | 32'h1;
    if (n == 0)     s = s | 32'h2;
    if (m_ovf)      s = s | 32'h4;
    return s;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    if (w < 32'h100)          return m_ram[a[7:2]];
    else if (w == 32'h1000)   return m_cycle;
    else if (w == 32'h1008)   return m_status();
    else                      return 32'h0;
  endfunction

  // Model: apply one clock edge with the given inputs.
  task automatic m_update(input logic rst, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic rdy);
    logic [31:0] w;
    bit pop, push, drop;
    int n;
    w = addr & 32'hFFFF_FFFC;
    n = m_q.size();
    if (rst) begin
      m_cycle = 32'h0;
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      pop  = (n != 0) && rdy;
      push = we && (w == 32'h1004);
      drop = push && (n == DEPTH) && !pop;
      if (we && w < 32'h100) m_ram[addr[7:2]] = wd;
      m_cycle = (we && w == 32'h1000) ? wd : m_cycle + 32'd1;
      if (pop) void'(m_q.pop_front());
      if (push && !drop) m_q.push_back(wd[7:0]);
      if (drop) m_ovf = 1'b1;
      else if (we && w == 32'h1008 && wd[2]) m_ovf = 1'b0;
    end
  endtask

  // One model-checked cycle.
  task automatic rstep(input logic rst, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic rdy, input logic chk_rd);
    drive(rst, we, addr, wd, rdy);
    #1;
    if (chk_rd) check32("rnd_rdata", bus_if.ReadData, m_read(addr));
    check1("rnd_valid", bus_if.con_valid, m_q.size() != 0);
    if (m_q.size() != 0) check8("rnd_con_data", bus_if.con_data, m_q[0]);
    @(posedge clk);
    m_update(rst, we, addr, wd, rdy);
    @(negedge clk);
  endtask

  task automatic run_random(input int n);
    logic [31:0] a, d;
    logic we, rst, rdy;
    int sel;
    for (int i = 0; i < n; i++) begin
      sel = $urandom_range(0, 99);
      d = $urandom();
      if (sel < 35)      a = 32'h1004 | 32'($urandom_range(0, 3));
      else if (sel < 55) a = 32'($urandom_range(0, 255));
      else if (sel < 65) a = 32'h1008 | 32'($urandom_range(0, 3));
      else if (sel < 72) begin
        a = 32'h1000 | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      end
      else if (sel < 85) a = 32'($urandom_range(256, 4095));
      else               a = $urandom();
      we  = ($urandom_range(0, 99) < 60);
      // Alternate slow-drain and fast-drain phases so the FIFO both fills and empties.
      if (((i / 64) % 2) == 0) rdy = ($urandom_range(0, 3) == 0);
      else                     rdy = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) == 0);
      rstep(rst, we, a, d, rdy, 1'b1);
    end
  endtask

  initial begin
    m_ovf = 1'b0;
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);

    //  rst we   addr          wd            rdy  chk rd            v     chk d
    add(0, 0, 32'h1000, 32'h0,           0,  1, 32'h0000_0000, 0,  0, 8'h00); // 0 cycle cleared
    add(0, 0, 32'h1008, 32'h0,           0,  1, 32'h0000_0002, 0,  0, 8'h00); // 1 status empty
    add(0, 0, 32'h1004, 32'h0,           0,  1, 32'h0000_0000, 0,  0, 8'h00); // 2 contx reads 0
    add(0, 1, 32'h0010, 32'h1111_1111,   0,  0, 32'h0,         0,  0, 8'h00); // 3
    add(0, 1, 32'h0010, 32'hDEAD_BEEF,   0,  1, 32'h1111_1111, 0,  0, 8'h00); // 4 old word
    add(0, 0, 32'h0010, 32'h0,           0,  1, 32'hDEAD_BEEF, 0,  0, 8'h00); // 5
    add(0, 0, 32'h0013, 32'h0,           0,  1, 32'hDEAD_BEEF, 0,  0, 8'h00); // 6 lsbs ignored
    add(0, 1, 32'h00FC, 32'hA5A5_0001,   0,  0, 32'h0,         0,  0, 8'h00); // 7 last word
    add(0, 0, 32'h00FF, 32'h0,           0,  1, 32'hA5A5_0001, 0,  0, 8'h00); // 8
    add(0, 0, 32'h0100, 32'h0,           0,  1, 32'h0000_0000, 0,  0, 8'h00); // 9 just past RAM
    add(0, 1, 32'h2000, 32'hFFFF_FFFF,   0,  1, 32'h0000_0000, 0,  0, 8'h00); // 10 unmapped store
    add(0, 0, 32'h2000, 32'h0,           0,  1, 32'h0000_0000, 0,  0, 8'h00); // 11
    add(0, 0, 32'h0010, 32'h0,           0,  1, 32'hDEAD_BEEF, 0,  0, 8'h00); // 12
    add(0, 1, 32'h1000, 32'hFFFF_FFFE,   0,  1, 32'h0000_000D, 0,  0, 8'h00); // 13 cycle=13
    add(0, 0, 32'h1000, 32'h0,           0,  1, 32'hFFFF_FFFE, 0,  0, 8'h00); // 14
    add(0, 0, 32'h1000, 32'h0,           0,  1, 32'hFFFF_FFFF, 0,  0, 8'h00); // 15
    add(0, 0, 32'h1000, 32'h0,           0,  1, 32'h0000_0000, 0,  0, 8'h00); // 16 wrap
    add(0, 1, 32'h1004, 32'h0000_0041,   0,  1, 32'h0000_0000, 0,  0, 8'h00); // 17
    add(0, 1, 32'h1004, 32'h0000_0042,   0,  1, 32'h0000_0000, 1,  1, 8'h41); // 18 1-cycle latency
    add(0, 1, 32'h1004, 32'h0000_0043,   0,  0, 32'h0,         1,  1, 8'h41); // 19
    add(0, 1, 32'h1004, 32'h0000_0044,   0,  0, 32'h0,         1,  1, 8'h41); // 20
    add(0, 1, 32'h1004, 32'h0000_0045,   0,  0, 32'h0,         1,  1, 8'h41); // 21 dropped
    add(0, 0, 32'h1008, 32'h0,           0,  1, 32'h0000_0025, 1,  1, 8'h41); // 22
    add(0, 0, 32'h1008, 32'h0,           1,  1, 32'h0000_0025, 1,  1, 8'h41); // 23
    add(0, 0, 32'h1008, 32'h0,           1,  1, 32'h0000_001C, 1,  1, 8'h42); // 24
    add(0, 0, 32'h1008, 32'h0,           1,  1, 32'h0000_0014, 1,  1, 8'h43); // 25
    add(0, 0, 32'h1008, 32'h0,           1,  1, 32'h0000_000C, 1,  1, 8'h44); // 26
    add(0, 0, 32'h1008, 32'h0,           1,  1, 32'h0000_0006, 0,  0, 8'h00); // 27
    add(0, 1, 32'h1008, 32'h0000_0004,   1,  1, 32'h0000_0006, 0,  0, 8'h00); // 28 clear ovf
    add(0, 0, 32'h1008, 32'h0,           1,  1, 32'h0000_0002, 0,  0, 8'h00); // 29
    add(0, 1, 32'h1004, 32'h0000_0051,   0,  1, 32'h0000_0000, 0,  0, 8'h00); // 30
    add(0, 1, 32'h1004, 32'h0000_0052,   0,  0, 32'h0,         1,  1, 8'h51); // 31
    add(0, 1, 32'h1004, 32'h0000_0053,   0,  0, 32'h0,         1,  1, 8'h51); // 32
    add(0, 1, 32'h1004, 32'h0000_0054,   0,  0, 32'h0,         1,  1, 8'h51); // 33
    add(0, 1, 32'h1004, 32'h0000_0055,   1,  0, 32'h0,         1,  1, 8'h51); // 34 full push+pop
    add(0, 0, 32'h1008, 32'h0,           0,  1, 32'h0000_0021, 1,  1, 8'h52); // 35
    add(0, 0, 32'h1008, 32'h0,           1,  1, 32'h0000_0021, 1,  1, 8'h52); // 36
    add(0, 0, 32'h1008, 32'h0,           1,  1, 32'h0000_0018, 1,  1, 8'h53); // 37
    add(0, 0, 32'h1008, 32'h0,           1,  1, 32'h0000_0010, 1,  1, 8'h54); // 38
    add(0, 0, 32'h1008, 32'h0,           1,  1, 32'h0000_0008, 1,  1, 8'h55); // 39
    add(0, 0, 32'h1008, 32'h0,           1,  1, 32'h0000_0002, 0,  0, 8'h00); // 40
    add(0, 1, 32'h1004, 32'h0000_0061,   0,  0, 32'h0,         0,  0, 8'h00); // 41
    add(0, 1, 32'h1004, 32'h0000_0062,   0,  0, 32'h0,         1,  1, 8'h61); // 42
    add(0, 1, 32'h1004, 32'h0000_0063,   0,  0, 32'h0,         1,  1, 8'h61); // 43
    add(1, 0, 32'h1008, 32'h0,           0,  1, 32'h0000_0018, 1,  1, 8'h61); // 44 reset, 3 queued
    add(0, 0, 32'h1000, 32'h0,           0,  1, 32'h0000_0000, 0,  0, 8'h00); // 45
    add(0, 0, 32'h1008, 32'h0,           0,  1, 32'h0000_0002, 0,  0, 8'h00); // 46
    add(0, 0, 32'h0010, 32'h0,           0,  1, 32'hDEAD_BEEF, 0,  0, 8'h00); // 47 RAM kept
    add(1, 1, 32'h1000, 32'h1234_5678,   0,  1, 32'h0000_0003, 0,  0, 8'h00); // 48 reset vs store
    add(0, 0, 32'h1000, 32'h0,           0,  1, 32'h0000_0000, 0,  0, 8'h00); // 49
    add(1, 1, 32'h1004, 32'h0000_0077,   1,  1, 32'h0000_0000, 0,  0, 8'h00); // 50 reset vs push
    add(0, 0, 32'h1008, 32'h0,           0,  1, 32'h0000_0002, 0,  0, 8'h00); // 51
    add(1, 1, 32'h0010, 32'hBAD0_BAD0,   0,  1, 32'hDEAD_BEEF, 0,  0, 8'h00); // 52 reset vs RAM store
    add(0, 0, 32'h0010, 32'h0,           0,  1, 32'hDEAD_BEEF, 0,  0, 8'h00); // 53

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].rdy);
      #1;
      if (vecs[i].chk_rd) check32($sformatf("vec%0d_rdata", i), bus_if.ReadData, vecs[i].exp_rd);
      check1($sformatf("vec%0d_valid", i), bus_if.con_valid, vecs[i].exp_v);
      if (vecs[i].chk_d) check8($sformatf("vec%0d_con_data", i), bus_if.con_data, vecs[i].exp_d);
      tick();
    end

    // Hand sequence: push and pop together at count 2 keeps the count and the order.
    drive(0, 1, 32'h1004, 32'h81, 0); #1;
    check1("seq_valid0", bus_if.con_valid, 1'b0); tick();
    drive(0, 1, 32'h1004, 32'h82, 0); #1;
    check8("seq_head81a", bus_if.con_data, 8'h81); tick();
    drive(0, 1, 32'h1004, 32'h83, 1); #1;
    check8("seq_head81b", bus_if.con_data, 8'h81); tick();
    drive(0, 0, 32'h1008, 32'h0, 0); #1;
    check32("seq_status2", bus_if.ReadData, 32'h10);
    check8("seq_head82a", bus_if.con_data, 8'h82); tick();
    drive(0, 0, 32'h1008, 32'h0, 1); #1;
    check8("seq_head82b", bus_if.con_data, 8'h82); tick();
    drive(0, 0, 32'h1008, 32'h0, 1); #1;
    check8("seq_head83", bus_if.con_data, 8'h83);
    check32("seq_status1", bus_if.ReadData, 32'h08); tick();
    drive(0, 0, 32'h1008, 32'h0, 0); #1;
    check1("seq_valid_end", bus_if.con_valid, 1'b0);
    check32("seq_status0", bus_if.ReadData, 32'h02); tick();

    // Randomized traffic against the model: sync with a reset, fill RAM, then run.
    rstep(1'b1, 1'b0, 32'h1008, 32'h0, 1'b0, 1'b1);
    for (int k = 0; k < 64; k++) rstep(1'b0, 1'b1, 32'(k * 4), $urandom(), 1'b1, 1'b0);
    run_random(3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
